// File: rtl/reg_access_arb_if.sv
// Requester/bank bundle for the register-table access arbiter.
// slave is the arbiter's view; master is the requester and register-bank side.
interface reg_access_arb_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    logic              spi_req;
    logic              spi_wr;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_din;
    logic              ttehash_req;
    logic              port0_req;
    logic              port1_req;
    logic              port2_req;
    logic              port3_req;
    logic [ADDR_W-1:0] port0_addr;
    logic [ADDR_W-1:0] port1_addr;
    logic [ADDR_W-1:0] port2_addr;
    logic [ADDR_W-1:0] port3_addr;
    logic [DATA_W-1:0] port0_din;
    logic [DATA_W-1:0] port1_din;
    logic [DATA_W-1:0] port2_din;
    logic [DATA_W-1:0] port3_din;
    logic [DATA_W-1:0] rf_rdata;

    logic              spi_ack;
    logic              ttehash_ack;
    logic              port0_ack;
    logic              port1_ack;
    logic              port2_ack;
    logic              port3_ack;
    logic [DATA_W-1:0] spi_dout;
    logic              rf_we;
    logic              rf_re;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              hash_update;

    modport slave (
        input  spi_req, spi_wr, spi_addr, spi_din, ttehash_req,
        input  port0_req, port1_req, port2_req, port3_req,
        input  port0_addr, port1_addr, port2_addr, port3_addr,
        input  port0_din, port1_din, port2_din, port3_din, rf_rdata,
        output spi_ack, ttehash_ack, port0_ack, port1_ack, port2_ack, port3_ack,
        output spi_dout, rf_we, rf_re, rf_addr, rf_wdata, hash_update
    );

    modport master (
        output spi_req, spi_wr, spi_addr, spi_din, ttehash_req,
        output port0_req, port1_req, port2_req, port3_req,
        output port0_addr, port1_addr, port2_addr, port3_addr,
        output port0_din, port1_din, port2_din, port3_din, rf_rdata,
        input  spi_ack, ttehash_ack, port0_ack, port1_ack, port2_ack, port3_ack,
        input  spi_dout, rf_we, rf_re, rf_addr, rf_wdata, hash_update
    );
endinterface

// File: rtl/reg_access_arb.sv
// Serializes SPI, TTE-hash and four switch-port requests onto the single
// register-bank access port; fixed SPI > hash priority, round-robin among ports.
module reg_access_arb #(
    parameter int unsigned RF_LAT = 2
) (
    input logic             clk,
    input logic             rst_n,
    reg_access_arb_if.slave bus
);
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned OWN_W  = 3;
    localparam int unsigned NPORT  = 4;

    // Owner codes 0..3 are the switch ports themselves.
    localparam logic [OWN_W-1:0] OWN_SPI  = 3'd4;
    localparam logic [OWN_W-1:0] OWN_HASH = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [OWN_W-1:0]  owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ptr_q, ptr_d;

    logic              spi_ack_q, spi_ack_d;
    logic              hash_ack_q, hash_ack_d;
    logic [NPORT-1:0]  port_ack_q, port_ack_d;
    logic [DATA_W-1:0] spi_dout_q, spi_dout_d;
    logic              rf_we_q, rf_we_d;
    logic              rf_re_q, rf_re_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              hash_update_q, hash_update_d;

    logic [NPORT-1:0]  port_req;
    logic [ADDR_W-1:0] port_addr [NPORT];
    logic [DATA_W-1:0] port_din  [NPORT];
    logic              rr_found;
    logic [1:0]        rr_idx;
    logic              owner_req;

    assign port_req = {bus.port3_req, bus.port2_req, bus.port1_req, bus.port0_req};

    always_comb begin
        port_addr[0] = bus.port0_addr;
        port_addr[1] = bus.port1_addr;
        port_addr[2] = bus.port2_addr;
        port_addr[3] = bus.port3_addr;
        port_din[0]  = bus.port0_din;
        port_din[1]  = bus.port1_din;
        port_din[2]  = bus.port2_din;
        port_din[3]  = bus.port3_din;
    end

    // Round-robin search starting at the pointer, wrapping 3 -> 0.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        for (int i = 0; i < int'(NPORT); i++) begin
            if (!rr_found && port_req[2'(ptr_q + 2'(i))]) begin
                rr_found = 1'b1;
                rr_idx   = 2'(ptr_q + 2'(i));
            end
        end
    end

    always_comb begin
        case (owner_q)
            OWN_SPI:  owner_req = bus.spi_req;
            OWN_HASH: owner_req = bus.ttehash_req;
            default:  owner_req = port_req[owner_q[1:0]];
        endcase
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        spi_dout_d    = spi_dout_q;
        rf_addr_d     = rf_addr_q;
        rf_wdata_d    = rf_wdata_q;
        spi_ack_d     = 1'b0;
        hash_ack_d    = 1'b0;
        port_ack_d    = '0;
        rf_we_d       = 1'b0;
        rf_re_d       = 1'b0;
        hash_update_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.spi_req) begin
                    owner_d   = OWN_SPI;
                    wr_d      = bus.spi_wr;
                    rf_addr_d = bus.spi_addr;
                    if (bus.spi_wr) begin
                        rf_wdata_d = bus.spi_din;
                        rf_we_d    = 1'b1;
                    end else begin
                        rf_re_d    = 1'b1;
                    end
                    state_d = S_ISSUE;
                end else if (bus.ttehash_req) begin
                    owner_d       = OWN_HASH;
                    wr_d          = 1'b0;
                    hash_update_d = 1'b1;
                    state_d       = S_ISSUE;
                end else if (rr_found) begin
                    owner_d    = {1'b0, rr_idx};
                    wr_d       = 1'b1;
                    rf_addr_d  = port_addr[rr_idx];
                    rf_wdata_d = port_din[rr_idx];
                    rf_we_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(RF_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    if (owner_q == OWN_SPI) begin
                        spi_ack_d = 1'b1;
                        if (!wr_q) spi_dout_d = bus.rf_rdata;
                    end else if (owner_q == OWN_HASH) begin
                        hash_ack_d = 1'b1;
                    end else begin
                        port_ack_d[owner_q[1:0]] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                if (!owner_q[2]) ptr_d = 2'(owner_q[1:0] + 2'd1);
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!owner_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            owner_q       <= '0;
            wr_q          <= 1'b0;
            cnt_q         <= '0;
            ptr_q         <= '0;
            spi_ack_q     <= 1'b0;
            hash_ack_q    <= 1'b0;
            port_ack_q    <= '0;
            spi_dout_q    <= '0;
            rf_we_q       <= 1'b0;
            rf_re_q       <= 1'b0;
            rf_addr_q     <= '0;
            rf_wdata_q    <= '0;
            hash_update_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            spi_ack_q     <= spi_ack_d;
            hash_ack_q    <= hash_ack_d;
            port_ack_q    <= port_ack_d;
            spi_dout_q    <= spi_dout_d;
            rf_we_q       <= rf_we_d;
            rf_re_q       <= rf_re_d;
            rf_addr_q     <= rf_addr_d;
            rf_wdata_q    <= rf_wdata_d;
            hash_update_q <= hash_update_d;
        end
    end

    assign bus.spi_ack     = spi_ack_q;
    assign bus.ttehash_ack = hash_ack_q;
    assign bus.port0_ack   = port_ack_q[0];
    assign bus.port1_ack   = port_ack_q[1];
    assign bus.port2_ack   = port_ack_q[2];
    assign bus.port3_ack   = port_ack_q[3];
    assign bus.spi_dout    = spi_dout_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_re       = rf_re_q;
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.hash_update = hash_update_q;
endmodule

// File: tb/tb_reg_access_arb.sv
// Directed bench for reg_access_arb: main build with RF_LAT=2 plus
// RF_LAT=1 and RF_LAT=7 builds for read-latency checks.
module tb_reg_access_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    reg_access_arb_if bus ();
    reg_access_arb_if bus1 ();
    reg_access_arb_if bus7 ();

    reg_access_arb #(.RF_LAT(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    reg_access_arb #(.RF_LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    reg_access_arb #(.RF_LAT(7)) u_lat7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

    // Bank models: read data is valid only in the cycle RF_LAT after rf_re.
    logic [15:0] rd_val2, rd_val1, rd_val7;
    logic [7:0]  pipe2, pipe1, pipe7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe2 <= '0;
            pipe1 <= '0;
            pipe7 <= '0;
        end else begin
            pipe2 <= {pipe2[6:0], bus.rf_re};
            pipe1 <= {pipe1[6:0], bus1.rf_re};
            pipe7 <= {pipe7[6:0], bus7.rf_re};
        end
    end

    assign bus.rf_rdata  = pipe2[1] ? rd_val2 : 16'hDEAD;
    assign bus1.rf_rdata = pipe1[0] ? rd_val1 : 16'hDEAD;
    assign bus7.rf_rdata = pipe7[6] ? rd_val7 : 16'hDEAD;

    function automatic logic [8:0] ctrl_outs();
        return {bus.spi_ack, bus.ttehash_ack, bus.port3_ack, bus.port2_ack,
                bus.port1_ack, bus.port0_ack, bus.rf_we, bus.rf_re, bus.hash_update};
    endfunction

    function automatic logic [3:0] port_acks();
        return {bus.port3_ack, bus.port2_ack, bus.port1_ack, bus.port0_ack};
    endfunction

    task automatic set_port(input int i, input logic r, input logic [6:0] a, input logic [15:0] d);
        case (i)
            0: begin bus.port0_req = r; bus.port0_addr = a; bus.port0_din = d; end
            1: begin bus.port1_req = r; bus.port1_addr = a; bus.port1_din = d; end
            2: begin bus.port2_req = r; bus.port2_addr = a; bus.port2_din = d; end
            default: begin bus.port3_req = r; bus.port3_addr = a; bus.port3_din = d; end
        endcase
    endtask

    task automatic set_port_req(input int i, input logic r);
        case (i)
            0: bus.port0_req = r;
            1: bus.port1_req = r;
            2: bus.port2_req = r;
            default: bus.port3_req = r;
        endcase
    endtask

    task automatic clear_inputs();
        bus.spi_req = 0; bus.spi_wr = 0; bus.spi_addr = '0; bus.spi_din = '0; bus.ttehash_req = 0;
        bus1.spi_req = 0; bus1.spi_wr = 0; bus1.spi_addr = '0; bus1.spi_din = '0; bus1.ttehash_req = 0;
        bus7.spi_req = 0; bus7.spi_wr = 0; bus7.spi_addr = '0; bus7.spi_din = '0; bus7.ttehash_req = 0;
        for (int i = 0; i < 4; i++) set_port(i, 1'b0, '0, '0);
        bus1.port0_req = 0; bus1.port1_req = 0; bus1.port2_req = 0; bus1.port3_req = 0;
        bus1.port0_addr = '0; bus1.port1_addr = '0; bus1.port2_addr = '0; bus1.port3_addr = '0;
        bus1.port0_din = '0; bus1.port1_din = '0; bus1.port2_din = '0; bus1.port3_din = '0;
        bus7.port0_req = 0; bus7.port1_req = 0; bus7.port2_req = 0; bus7.port3_req = 0;
        bus7.port0_addr = '0; bus7.port1_addr = '0; bus7.port2_addr = '0; bus7.port3_addr = '0;
        bus7.port0_din = '0; bus7.port1_din = '0; bus7.port2_din = '0; bus7.port3_din = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        repeat (3) @(negedge clk);
        n_cmp++; if (ctrl_outs() !== 9'd0) begin n_err++; $display("FAIL reset_ctrl: got %b want 000000000", ctrl_outs()); end
        n_cmp++; if (bus.rf_addr !== 7'h00) begin n_err++; $display("FAIL reset_rf_addr: got %h want 00", bus.rf_addr); end
        n_cmp++; if (bus.rf_wdata !== 16'h0000) begin n_err++; $display("FAIL reset_rf_wdata: got %h want 0000", bus.rf_wdata); end
        n_cmp++; if (bus.spi_dout !== 16'h0000) begin n_err++; $display("FAIL reset_spi_dout: got %h want 0000", bus.spi_dout); end
        rst_n = 1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ctrl_outs() !== 9'd0) begin n_err++; $display("FAIL idle_quiet: got %b want 000000000", ctrl_outs()); end
    endtask

    task automatic test_simultaneous();
        int          order[$];
        logic [22:0] wlog[$];
        int          exp_order[4] = '{4, 5, 0, 1};
        logic [22:0] exp_w[3] = '{{7'h02, 16'h0055}, {7'h10, 16'h0010}, {7'h13, 16'h0011}};
        int          hash_cnt = 0;
        int          viol = 0;
        int          cyc = 0;
        int          got;
        logic [22:0] gw;
        bus.spi_req = 1; bus.spi_wr = 1; bus.spi_addr = 7'h02; bus.spi_din = 16'h0055;
        bus.ttehash_req = 1;
        set_port(0, 1'b1, 7'h10, 16'h0010);
        set_port(1, 1'b1, 7'h13, 16'h0011);
        while (order.size() < 4 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (bus.rf_we) wlog.push_back({bus.rf_addr, bus.rf_wdata});
            if (bus.hash_update) hash_cnt++;
            if ($countones({bus.rf_we, bus.rf_re, bus.hash_update}) > 1 ||
                $countones(ctrl_outs() >> 3) > 1) viol++;
            if (bus.spi_ack)     begin order.push_back(4); bus.spi_req = 0; end
            if (bus.ttehash_ack) begin order.push_back(5); bus.ttehash_req = 0; end
            if (bus.port0_ack)   begin order.push_back(0); bus.port0_req = 0; end
            if (bus.port1_ack)   begin order.push_back(1); bus.port1_req = 0; end
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < order.size()) ? order[k] : -1;
            n_cmp++; if (got !== exp_order[k]) begin n_err++; $display("FAIL simul_order[%0d]: got owner %0d want %0d", k, got, exp_order[k]); end
        end
        n_cmp++; if (wlog.size() != 3) begin n_err++; $display("FAIL simul_write_count: got %0d want 3", wlog.size()); end
        for (int k = 0; k < 3; k++) begin
            gw = (k < wlog.size()) ? wlog[k] : 23'h7fffff;
            n_cmp++; if (gw !== exp_w[k]) begin n_err++; $display("FAIL simul_write[%0d]: got %h want %h", k, gw, exp_w[k]); end
        end
        n_cmp++; if (hash_cnt != 1) begin n_err++; $display("FAIL simul_hash_pulses: got %0d want 1", hash_cnt); end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL simul_onehot: got %0d violations want 0", viol); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_spi_read();
        int k = 0;
        rd_val2 = 16'h1234;
        bus.spi_req = 1; bus.spi_wr = 0; bus.spi_addr = 7'h00;
        @(negedge clk);
        n_cmp++; if ({bus.rf_re, bus.rf_we, bus.rf_addr} !== {1'b1, 1'b0, 7'h00}) begin
            n_err++; $display("FAIL read_strobe: got re=%b we=%b addr=%h want re=1 we=0 addr=00", bus.rf_re, bus.rf_we, bus.rf_addr); end
        while (bus.spi_ack !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (k != 3) begin n_err++; $display("FAIL read_ack_latency: got %0d want 3", k); end
        n_cmp++; if (bus.spi_dout !== 16'h1234) begin n_err++; $display("FAIL read_data: got %h want 1234", bus.spi_dout); end
        bus.spi_req = 0;
        repeat (4) @(negedge clk);
        n_cmp++; if ({bus.spi_ack, bus.spi_dout} !== {1'b0, 16'h1234}) begin
            n_err++; $display("FAIL read_data_held: got ack=%b dout=%h want ack=0 dout=1234", bus.spi_ack, bus.spi_dout); end
    endtask

    task automatic test_round_robin();
        int          order[$];
        logic [6:0]  alog[$];
        int          rearm[4] = '{-1, -1, -1, -1};
        int          exp_order[5] = '{0, 1, 2, 3, 0};
        int          cyc = 0;
        int          got;
        logic [6:0]  ga;
        logic [3:0]  acks;
        for (int i = 0; i < 4; i++) set_port(i, 1'b1, 7'(7'h20 + i), 16'(16'h0100 + i));
        while (order.size() < 5 && cyc < 300) begin
            @(negedge clk); cyc++;
            for (int i = 0; i < 4; i++) if (rearm[i] == cyc) set_port_req(i, 1'b1);
            if (bus.rf_we) alog.push_back(bus.rf_addr);
            acks = port_acks();
            for (int i = 0; i < 4; i++) begin
                if (acks[i]) begin
                    order.push_back(i);
                    set_port_req(i, 1'b0);
                    rearm[i] = cyc + 2;
                end
            end
        end
        for (int i = 0; i < 4; i++) set_port_req(i, 1'b0);
        for (int k = 0; k < 5; k++) begin
            got = (k < order.size()) ? order[k] : -1;
            n_cmp++; if (got !== exp_order[k]) begin n_err++; $display("FAIL rr_order[%0d]: got port %0d want %0d", k, got, exp_order[k]); end
        end
        ga = (alog.size() >= 5) ? alog[4] : 7'h7f;
        n_cmp++; if (ga !== 7'h20) begin n_err++; $display("FAIL rr_wrap_addr: got %h want 20", ga); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_stuck();
        int         k = 0;
        int         p2_extra = 0;
        int         p3_early = 0;
        int         strobes = 0;
        logic [3:0] first = 4'h0;
        logic [6:0] p3_addr = 7'h7f;
        set_port(2, 1'b1, 7'h32, 16'h2222);
        set_port(3, 1'b1, 7'h33, 16'h3333);
        while (port_acks() == 4'h0 && k < 50) begin @(negedge clk); k++; end
        first = port_acks();
        n_cmp++; if (first !== 4'b0100) begin n_err++; $display("FAIL stuck_first_ack: got %b want 0100", first); end
        repeat (10) begin
            @(negedge clk);
            if (bus.port2_ack) p2_extra++;
            if (bus.port3_ack) p3_early++;
            if (bus.rf_we | bus.rf_re | bus.hash_update) strobes++;
        end
        n_cmp++; if ({p3_early, strobes} != {32'd0, 32'd0}) begin
            n_err++; $display("FAIL stuck_held: got port3 acks=%0d strobes=%0d want 0 0", p3_early, strobes); end
        bus.port2_req = 0;
        k = 0;
        while (bus.port3_ack !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
            if (bus.port2_ack) p2_extra++;
            if (bus.rf_we) p3_addr = bus.rf_addr;
        end
        n_cmp++; if (k != 5) begin n_err++; $display("FAIL stuck_port3_latency: got %0d want 5", k); end
        n_cmp++; if (p3_addr !== 7'h33) begin n_err++; $display("FAIL stuck_port3_addr: got %h want 33", p3_addr); end
        n_cmp++; if (p2_extra != 0) begin n_err++; $display("FAIL stuck_port2_reserved: got %0d want 0", p2_extra); end
        bus.port3_req = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int p0_acks = 0;
        set_port(0, 1'b1, 7'h40, 16'hBEEF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        n_cmp++; if ({ctrl_outs(), bus.rf_addr, bus.rf_wdata, bus.spi_dout} !== 48'd0) begin
            n_err++; $display("FAIL mid_reset_outputs: got ctrl=%b addr=%h wdata=%h dout=%h want all 0",
                              ctrl_outs(), bus.rf_addr, bus.rf_wdata, bus.spi_dout); end
        repeat (3) begin @(negedge clk); if (bus.port0_ack) p0_acks++; end
        n_cmp++; if (p0_acks != 0) begin n_err++; $display("FAIL mid_reset_no_ack: got %0d want 0", p0_acks); end
        rst_n = 1;
        @(negedge clk);
        n_cmp++; if ({bus.rf_we, bus.rf_addr, bus.rf_wdata} !== {1'b1, 7'h40, 16'hBEEF}) begin
            n_err++; $display("FAIL mid_reset_reissue: got we=%b addr=%h wdata=%h want 1 40 beef", bus.rf_we, bus.rf_addr, bus.rf_wdata); end
        while (bus.port0_ack !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (k != 3) begin n_err++; $display("FAIL mid_reset_ack_latency: got %0d want 3", k); end
        bus.port0_req = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lat_builds();
        int k = 0;
        rd_val1 = 16'hA1A1;
        rd_val7 = 16'h7777;
        bus1.spi_req = 1; bus1.spi_wr = 0; bus1.spi_addr = 7'h00;
        @(negedge clk);
        n_cmp++; if (bus1.rf_re !== 1'b1) begin n_err++; $display("FAIL lat1_strobe: got %b want 1", bus1.rf_re); end
        while (bus1.spi_ack !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_cmp++; if (k != 2) begin n_err++; $display("FAIL lat1_ack_latency: got %0d want 2", k); end
        n_cmp++; if (bus1.spi_dout !== 16'hA1A1) begin n_err++; $display("FAIL lat1_data: got %h want a1a1", bus1.spi_dout); end
        bus1.spi_req = 0;
        k = 0;
        bus7.spi_req = 1; bus7.spi_wr = 0; bus7.spi_addr = 7'h00;
        @(negedge clk);
        n_cmp++; if (bus7.rf_re !== 1'b1) begin n_err++; $display("FAIL lat7_strobe: got %b want 1", bus7.rf_re); end
        while (bus7.spi_ack !== 1'b1 && k < 30) begin @(negedge clk); k++; end
        n_cmp++; if (k != 8) begin n_err++; $display("FAIL lat7_ack_latency: got %0d want 8", k); end
        n_cmp++; if (bus7.spi_dout !== 16'h7777) begin n_err++; $display("FAIL lat7_data: got %h want 7777", bus7.spi_dout); end
        bus7.spi_req = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rd_val2 = 16'h0000;
        rd_val1 = 16'h0000;
        rd_val7 = 16'h0000;
        test_reset();
        test_simultaneous();
        test_spi_read();
        pulse_reset();
        test_round_robin();
        test_stuck();
        test_reset_mid();
        test_lat_builds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
